cellift_cover_accumulator: RTL
==============================

CELLIFT_COVER_ACCUMULATOR -- requirements
Module: cellift_cover_accumulator

Interface
REQ-001 SHALL have parameter NumCovers, default 172, the width of the coverage vector from the CPU top.
REQ-002 SHALL have parameter WordW, default 32, the dump word width; NumWords = ceil(NumCovers/WordW), which is 6 at defaults.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 cover_i  in  NumCovers  per-cycle coverage points from the CPU top (auto_cover_out).
REQ-007 en_i  in  1  accumulate enable; when low, cover_i is ignored.
REQ-008 clear_i  in  1  synchronous clear of all accumulated state.
REQ-009 dump_start_i  in  1  request to stream a snapshot of the sticky map.
REQ-010 dump_valid_o  out  1  dump word valid.
REQ-011 dump_ready_i  in  1  consumer accepts the dump word.
REQ-012 dump_data_o  out  WordW  dump word; word k carries sticky bits [k*WordW +: WordW], and bits beyond NumCovers read as zero.
REQ-013 dump_last_o  out  1  high with word NumWords-1.
REQ-014 busy_o  out  1  high while in state DUMP.
REQ-015 cov_cnt_o  out  CntW  number of set sticky bits, where CntW = clog2(NumCovers+1), which is 8 at defaults.
REQ-016 new_cov_o  out  1  one-cycle pulse: at least one new point was accumulated in the previous cycle.
REQ-017 stale_cycles_o  out  32  cycles since the last new point; saturates at 2^32-1.

Function
REQ-018 SHALL compute new = cover_i & ~sticky & {NumCovers{en_i}} each cycle.
REQ-019 SHALL set sticky |= new and cov_cnt += popcount(new) on the next edge; both are visible one cycle after cover_i.
REQ-020 SHALL register new_cov_o = |new, so the pulse appears one cycle after cover_i.
REQ-021 SHALL reset stale_cycles_o to 0 on an edge where |new; otherwise SHALL increment it, saturating at 0xFFFF_FFFF.
REQ-022 clear_i SHALL zero sticky, cov_cnt, stale_cycles and new_cov; clear wins over cover_i in the same cycle, and that cycle's cover_i is discarded.
REQ-023 SHALL use FSM states IDLE and DUMP.
REQ-024 IDLE->DUMP transition: on dump_start_i && !clear_i, copy sticky|new into the snapshot register and set word index to 0.
REQ-025 In DUMP, SHALL drive dump_valid_o=1 and dump_data_o=snapshot word[idx]; on valid&&ready, idx increments, and on the last word the FSM returns to IDLE.
REQ-026 SHALL hold dump_data_o and dump_last_o stable while valid && !ready; valid SHALL NOT drop without a handshake except on clear or reset.
REQ-027 SHALL ignore dump_start_i while in DUMP.
REQ-028 SHALL continue accumulation during DUMP; the snapshot is unaffected.
REQ-029 clear_i in DUMP SHALL abort the dump: next cycle IDLE with valid low and no dump_last_o emitted.
REQ-030 A dump start in the same cycle as the final handshake SHALL be ignored (FSM not in IDLE).
REQ-031 dump_valid_o SHALL be low in IDLE; the first word is valid in the cycle after dump_start_i.
REQ-032 cov_cnt SHALL never exceed NumCovers; no wrap is possible by construction.

Reset
REQ-033 rst_i SHALL set FSM to IDLE and zero sticky, snapshot, idx, cov_cnt_o, stale_cycles_o, new_cov_o, dump_valid_o, dump_last_o, busy_o and dump_data_o.
REQ-034 Reset mid-dump SHALL abort the dump with no further valid words.
REQ-035 rst_i SHALL take priority over clear_i, dump_start_i and cover_i.

Structure
REQ-036 Package cellift_cover_pkg SHALL hold NumCovers, WordW, NumWords, CntW and the enum dump_state_e {IDLE, DUMP}.
REQ-037 Sub-module cellift_cover_popcount (parameter N, combinational adder tree) SHALL compute popcount(new).
REQ-038 The block SHALL be instantiated beside the CPU top in the fuzzing SoC, consuming auto_cover_out.

Verification
REQ-039 Accumulate: en=1; cover_i=bit0|bit5 at cycle 1, then bit5|bit171 at cycle 2 -> cov_cnt 2 then 3; new_cov pulses twice; sticky bits {0,5,171} are set.
REQ-040 Disabled: en=0; cover_i all-ones for 10 cycles -> cov_cnt 0, new_cov 0, stale_cycles reaches 10.
REQ-041 Dump with backpressure: sticky={0,33,171}; ready toggles 0,1 -> 6 words 0x1, 0x2, 0, 0, 0, 0x800; last only on word 5; data stable across stalls.
REQ-042 Snapshot isolation: new bit 64 arrives during the dump -> dumped word 2 = 0; cov_cnt increments; a second dump shows word 2 = 0x1.
REQ-043 Clear priority and abort: clear_i with cover_i=bit7 during word 3 of a dump -> next cycle IDLE, valid 0, cov_cnt 0, bit7 not set.
REQ-044 Saturation/reset: force stale_cycles to 0xFFFF_FFFE, run 3 idle cycles -> value holds at 0xFFFF_FFFF; rst_i mid-dump -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/cellift_cover_pkg.sv
// Shared sizing constants and the dump FSM state type for the coverage accumulator.
package cellift_cover_pkg;

   localparam int unsigned NumCovers = 172;
   localparam int unsigned WordW     = 32;
   localparam int unsigned NumWords  = (NumCovers + WordW - 1) / WordW;
   localparam int unsigned CntW      = $clog2(NumCovers + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      DUMP = 1'b1
   } dump_state_e;

   // Number of dump words needed to carry a coverage vector of the given width.
   function automatic int unsigned words_for(input int unsigned covers, input int unsigned width);
      return (covers + width - 1) / width;
   endfunction

endpackage

// File: rtl/cellift_cover_popcount.sv
// Combinational population count built as a balanced adder tree.
module cellift_cover_popcount #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]               bits_i,
   output logic [$clog2(N + 1)-1:0]   count_o
);

   localparam int unsigned OutW   = $clog2(N + 1);
   localparam int unsigned Leaves = 1 << $clog2(N);

   logic [OutW-1:0] node [Leaves];

   // Pairwise reduction: each pass folds node[i+step] into node[i], halving the live leaves.
   always_comb begin
      for (int unsigned i = 0; i < Leaves; i++) begin
         node[i] = (i < N) ? OutW'(bits_i[i]) : '0;
      end
      for (int unsigned step = 1; step < Leaves; step = step * 2) begin
         for (int unsigned i = 0; i < Leaves; i = i + 2 * step) begin
            node[i] = node[i] + node[i + step];
         end
      end
      count_o = node[0];
   end

endmodule

// File: rtl/cellift_cover_accumulator.sv
// Sticky coverage accumulator with snapshot dump stream for the fuzzing SoC.
module cellift_cover_accumulator #(
   parameter int unsigned NumCovers = cellift_cover_pkg::NumCovers,
   parameter int unsigned WordW     = cellift_cover_pkg::WordW
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumCovers-1:0]             cover_i,
   input  logic                             en_i,
   input  logic                             clear_i,
   input  logic                             dump_start_i,
   output logic                             dump_valid_o,
   input  logic                             dump_ready_i,
   output logic [WordW-1:0]                 dump_data_o,
   output logic                             dump_last_o,
   output logic                             busy_o,
   output logic [$clog2(NumCovers + 1)-1:0] cov_cnt_o,
   output logic                             new_cov_o,
   output logic [31:0]                      stale_cycles_o
);

   import cellift_cover_pkg::*;

   localparam int unsigned Words   = words_for(NumCovers, WordW);
   localparam int unsigned CntBits = $clog2(NumCovers + 1);
   localparam int unsigned IdxBits = (Words > 1) ? $clog2(Words) : 1;
   localparam int unsigned SnapW   = Words * WordW;
   localparam logic [IdxBits-1:0] LastIdx = IdxBits'(Words - 1);

   logic [NumCovers-1:0] sticky_q, sticky_d;
   logic [NumCovers-1:0] new_w;
   logic [CntBits-1:0]   cnt_q, cnt_d, pop_w;
   logic [31:0]          stale_q, stale_d;
   logic                 newcov_q, newcov_d;

   dump_state_e          state_q;
   logic [WordW-1:0]     snap_q [Words];
   logic [IdxBits-1:0]   idx_q;
   logic [IdxBits-1:0]   idx_next_w;
   logic                 valid_q;
   logic                 last_q;
   logic [WordW-1:0]     data_q;
   logic [SnapW-1:0]     start_snap_w;

   assign new_w        = cover_i & ~sticky_q & {NumCovers{en_i}};
   // The snapshot includes points arriving in the start cycle, zero-padded to whole words.
   assign start_snap_w = SnapW'(sticky_q | new_w);
   assign idx_next_w   = idx_q + IdxBits'(1);

   cellift_cover_popcount #(
      .N(NumCovers)
   ) u_popcount (
      .bits_i (new_w),
      .count_o(pop_w)
   );

   // Next-state for the sticky map, hit counter, new-point pulse and staleness counter.
   always_comb begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      stale_d  = stale_q;
      newcov_d = 1'b0;
      if (clear_i) begin
         sticky_d = '0;
         cnt_d    = '0;
         stale_d  = '0;
      end else begin
         sticky_d = sticky_q | new_w;
         cnt_d    = cnt_q + pop_w;
         newcov_d = |new_w;
         if (|new_w) begin
            stale_d = '0;
         end else if (stale_q != '1) begin
            stale_d = stale_q + 32'd1;
         end
      end
   end

   // Accumulation registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sticky_q <= '0;
         cnt_q    <= '0;
         stale_q  <= '0;
         newcov_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         stale_q  <= stale_d;
         newcov_q <= newcov_d;
      end
   end

   // Dump FSM: captures a snapshot on start, then streams one word per handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         for (int unsigned k = 0; k < Words; k++) begin
            snap_q[k] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (dump_start_i && !clear_i) begin
                  state_q <= DUMP;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  last_q  <= (Words == 1);
                  data_q  <= start_snap_w[WordW-1:0];
                  for (int unsigned k = 0; k < Words; k++) begin
                     snap_q[k] <= start_snap_w[k*WordW +: WordW];
                  end
               end
            end
            DUMP: begin
               if (clear_i) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  data_q  <= '0;
               end else if (dump_ready_i) begin
                  if (last_q) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     data_q  <= '0;
                  end else begin
                     idx_q  <= idx_next_w;
                     data_q <= snap_q[idx_next_w];
                     last_q <= (idx_next_w == LastIdx);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               data_q  <= '0;
            end
         endcase
      end
   end

   assign dump_valid_o   = valid_q;
   assign dump_data_o    = data_q;
   assign dump_last_o    = last_q;
   assign busy_o         = (state_q == DUMP);
   assign cov_cnt_o      = cnt_q;
   assign new_cov_o      = newcov_q;
   assign stale_cycles_o = stale_q;

endmodule
